// File: rtl/axi_burst_rd_ctlr_if.sv
// Bundle for the burst read controller: request side, data-out stream and AXI4 AR/R channels.
// The master modport is the controller's view; slave is the environment's view.
interface axi_burst_rd_ctlr_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 16
);
    logic              RqValid;
    logic              RqReady;
    logic [ADDR_W-1:0] RqAddr;
    logic [LEN_W-1:0]  RqLen;
    logic              RqDone;
    logic              RqErr;

    logic              DoValid;
    logic              DoReady;
    logic [DATA_W-1:0] DoData;
    logic              DoLast;
    logic              DoErr;

    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;
    logic              arvalid;
    logic              arready;
    logic              arlock;
    logic [2:0]        arprot;
    logic [3:0]        arcache;
    logic [3:0]        arqos;

    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        input  RqValid, RqAddr, RqLen, DoReady, arready,
               rdata, rid, rresp, rlast, rvalid,
        output RqReady, RqDone, RqErr, DoValid, DoData, DoLast, DoErr,
               araddr, arlen, arsize, arburst, arid, arvalid,
               arlock, arprot, arcache, arqos, rready
    );

    modport slave (
        output RqValid, RqAddr, RqLen, DoReady, arready,
               rdata, rid, rresp, rlast, rvalid,
        input  RqReady, RqDone, RqErr, DoValid, DoData, DoLast, DoErr,
               araddr, arlen, arsize, arburst, arid, arvalid,
               arlock, arprot, arcache, arqos, rready
    );
endinterface

// File: rtl/axi_burst_rd_ctlr.sv
// AXI4 burst read master: splits one request into INCR bursts (MAX_BURST cap, no 4 KB crossing)
// and streams R beats out. Optional macro AXI_RD_ID_CHECK_EN flags beats whose rid != AXI_ID.
module axi_burst_rd_ctlr #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int AXI_ID    = 0
) (
    input  logic clk,
    input  logic rst,
    axi_burst_rd_ctlr_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Beats for the next burst: limited by what is left, the burst cap and the 4 KB page end.
    function automatic logic [8:0] burst_beats(input logic [LEN_W:0] rem,
                                               input logic [11:0] page_off);
        logic [12:0] page;
        logic [31:0] b;
        page = (13'd4096 - {1'b0, page_off}) >> SZ;
        b = 32'(rem);
        if (b > 32'(MAX_BURST)) b = 32'(MAX_BURST);
        if (b > 32'(page))      b = 32'(page);
        return 9'(b);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    rem_q, rem_d;
    logic [8:0]        beats_q, beats_d;
    logic [8:0]        bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic              arvalid_q, arvalid_d;

    logic [8:0] cur_beats;
    logic       in_r;
    logic       r_hs;
    logic       burst_end;
    logic       req_end;
    logic       id_bad;
    logic       beat_err;

`ifdef AXI_RD_ID_CHECK_EN
    assign id_bad = (bus.rid != ID_W'(AXI_ID));
`else
    logic unused_rid;
    assign unused_rid = ^bus.rid;
    assign id_bad     = 1'b0;
`endif

    assign cur_beats = burst_beats(rem_q, addr_q[11:0]);
    assign in_r      = (state_q == ST_R);
    assign r_hs      = in_r && bus.rvalid && bus.DoReady;
    assign burst_end = (bcnt_q == 9'd1);
    assign req_end   = (rem_q == (LEN_W+1)'(1));
    assign beat_err  = (bus.rresp != 2'h0) || id_bad;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        bcnt_d    = bcnt_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.RqValid) begin
                    addr_d    = {bus.RqAddr[ADDR_W-1:SZ], {SZ{1'b0}}};
                    rem_d     = (LEN_W+1)'(bus.RqLen) + (LEN_W+1)'(1);
                    err_d     = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (arvalid_q && bus.arready) begin
                    arvalid_d = 1'b0;
                    beats_d   = cur_beats;
                    bcnt_d    = cur_beats;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    bcnt_d = bcnt_q - 9'd1;
                    rem_d  = rem_q - (LEN_W+1)'(1);
                    // Burst length is owned by our counter; rlast is only cross-checked.
                    if (beat_err || (bus.rlast != burst_end)) err_d = 1'b1;
                    if (burst_end) begin
                        if (req_end) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d    = addr_q + (ADDR_W'(beats_q) << SZ);
                            arvalid_d = 1'b1;
                            state_d   = ST_AR;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            bcnt_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        beats_q <= beats_d;
    end

    assign bus.RqReady = (state_q == ST_IDLE);
    assign bus.RqDone  = (state_q == ST_DONE);
    assign bus.RqErr   = (state_q == ST_DONE) && err_q;

    assign bus.DoValid = in_r && bus.rvalid;
    assign bus.DoData  = bus.rdata;
    assign bus.DoLast  = in_r && req_end;
    assign bus.DoErr   = in_r && beat_err;
    assign bus.rready  = in_r && bus.DoReady;

    assign bus.araddr  = addr_q;
    assign bus.arlen   = 8'(cur_beats - 9'd1);
    assign bus.arvalid = arvalid_q;
    assign bus.arsize  = 3'(SZ);
    assign bus.arburst = 2'h1;
    assign bus.arid    = ID_W'(AXI_ID);
    assign bus.arlock  = 1'b0;
    assign bus.arprot  = 3'h2;
    assign bus.arcache = 4'h0;
    assign bus.arqos   = 4'h0;
endmodule

// File: tb/tb_axi_burst_rd_ctlr.sv
// Bench for axi_burst_rd_ctlr: request table plus an AXI slave model, with expected ARs,
// beats and completions queued at request time and checked as the DUT produces them.
module tb_axi_burst_rd_ctlr;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 128;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 16;
`ifdef AXI_RD_ID_CHECK_EN
    localparam bit ID_CHK = 1'b1;
`else
    localparam bit ID_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_burst_rd_ctlr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_burst_rd_ctlr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
        .MAX_BURST(16), .AXI_ID(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          err_beat;
        int          rl_beat;
        int          id_beat;
        bit          toggle;
        int          exp_nar;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        bit           last;
        bit           err;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    vec_t  vecs[9];
    beat_t do_q[$];
    ar_t   ar_q[$];
    bit    done_q[$];

    int total = 0;
    int bad = 0;
    int slv_k = 0;
    int cur_err = -1;
    int cur_rl = -1;
    int cur_id = -1;
    int ar_cnt = 0;
    int done_cnt = 0;
    bit prev_done = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k);
        return {32'hA5A5_0000 + 32'(k), ~32'(k), 32'(k * 3), 32'h1234_0000 ^ 32'(k)};
    endfunction

    // Expectations are queued here; the caller sits 1 time unit after a rising edge.
    task automatic start_vec(input vec_t v);
        logic [63:0] a;
        int rem, b, page;
        a = v.addr & ~64'hF;
        rem = v.len + 1;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 16;
            b = rem;
            if (b > 16) b = 16;
            if (b > page) b = page;
            ar_q.push_back('{a, 8'(b - 1)});
            a = a + 64'(b * 16);
            rem -= b;
        end
        for (int k = 0; k <= v.len; k++)
            do_q.push_back('{pat(k), (k == v.len), (k == v.err_beat) || (ID_CHK && k == v.id_beat)});
        done_q.push_back(v.exp_err);
        cur_err = v.err_beat;
        cur_rl  = v.rl_beat;
        cur_id  = v.id_beat;
        slv_k   = 0;
        ar_cnt  = 0;
        chk("rq_ready_idle", bus.RqReady, 1);
        bus.DoReady = 1'b1;
        bus.RqValid = 1'b1;
        bus.RqAddr  = v.addr;
        bus.RqLen   = LEN_W'(v.len);
        @(posedge clk); #1;
        bus.RqValid = 1'b0;
    endtask

    task automatic wait_done(input vec_t v, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (v.toggle) bus.DoReady = ~bus.DoReady;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no RqDone want RqDone within 2000 cycles");
        end
        bus.DoReady = 1'b1;
        chk("ar_count", 128'(ar_cnt), 128'(v.exp_nar));
        chk("beats_drained", 128'(do_q.size()), 0);
        chk("ars_drained", 128'(ar_q.size()), 0);
    endtask

    // AXI slave model: arready always high, R beats back-to-back, honouring rready.
    initial begin
        bit hs;
        int n;
        int e;
        ar_t x;
        bus.arready = 1'b1;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'h0;
        bus.rid     = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.arvalid && bus.arready) begin
                ar_cnt++;
                e = int'(bus.araddr[11:0]) + (int'(bus.arlen) + 1) * 16;
                chk("ar_no_4k_cross", (e <= 4096), 1);
                chk("ar_const", {bus.arsize, bus.arburst, bus.arid, bus.arlock, bus.arprot, bus.arcache, bus.arqos},
                    {3'd4, 2'd1, 4'd0, 1'b0, 3'd2, 4'd0, 4'd0});
                if (ar_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ar_unexpected: got araddr %0h want no AR", bus.araddr);
                end else begin
                    x = ar_q.pop_front();
                    chk("araddr", bus.araddr, x.addr);
                    chk("arlen", bus.arlen, x.len);
                end
                n = int'(bus.arlen) + 1;
                @(posedge clk); #1;
                for (int i = 0; i < n; i++) begin
                    if (rst) break;
                    bus.rvalid = 1'b1;
                    bus.rdata  = pat(slv_k);
                    bus.rresp  = (slv_k == cur_err) ? 2'h2 : 2'h0;
                    bus.rlast  = (i == n - 1) || (slv_k == cur_rl);
                    bus.rid    = (slv_k == cur_id) ? 4'h3 : 4'h0;
                    hs = 1'b0;
                    for (int t = 0; t < 200 && !hs && !rst; t++) begin
                        @(negedge clk);
                        if (bus.rvalid && bus.rready) hs = 1'b1;
                        @(posedge clk); #1;
                    end
                    if (!hs) begin
                        if (!rst) begin
                            total++;
                            bad++;
                            $display("FAIL r_handshake_timeout: got no rready want beat %0d taken", slv_k);
                        end
                        break;
                    end
                    slv_k++;
                end
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                bus.rresp  = 2'h0;
                bus.rid    = '0;
            end
        end
    end

    // Output monitor: data-out beats and request completions against the queues.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rvalid) chk("rready_tracks_doready", bus.rready, bus.DoReady);
                if (bus.DoValid && bus.DoReady) begin
                    if (do_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat_unexpected: got DoData %0h want no beat", bus.DoData);
                    end else begin
                        b = do_q.pop_front();
                        chk("do_data", bus.DoData, b.data);
                        chk("do_last", bus.DoLast, b.last);
                        chk("do_err", bus.DoErr, b.err);
                    end
                end
                if (bus.RqDone) begin
                    chk("done_one_cycle", prev_done, 0);
                    chk("rq_ready_in_done", bus.RqReady, 0);
                    if (done_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexpected: got RqDone want none");
                    end else begin
                        chk("rq_err", bus.RqErr, done_q.pop_front());
                    end
                    done_cnt++;
                end
                prev_done = bus.RqDone;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500000");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int d0;
        vecs[0] = '{64'h1000, 0, -1, -1, -1, 1'b0, 1, 1'b0};
        vecs[1] = '{64'h0000, 39, -1, -1, -1, 1'b0, 3, 1'b0};
        vecs[2] = '{64'h0FC0, 7, -1, -1, -1, 1'b0, 2, 1'b0};
        vecs[3] = '{64'h2000, 3, 1, -1, -1, 1'b1, 1, 1'b1};
        vecs[4] = '{64'h3000, 3, -1, 1, -1, 1'b0, 1, 1'b1};
        vecs[5] = '{64'h4000, 1, -1, -1, 0, 1'b0, 1, ID_CHK};
        vecs[6] = '{64'h0FF8, 2, -1, -1, -1, 1'b0, 2, 1'b0};
        vecs[7] = '{64'h5000, 16, -1, -1, -1, 1'b1, 2, 1'b0};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFF0, 1, -1, -1, -1, 1'b0, 2, 1'b0};

        bus.RqValid = 1'b0;
        bus.RqAddr  = '0;
        bus.RqLen   = '0;
        bus.DoReady = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_dovalid", bus.DoValid, 0);
        chk("rst_done_err", {bus.RqDone, bus.RqErr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rq_ready_after_rst", bus.RqReady, 1);

        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt;
            start_vec(vecs[i]);
            wait_done(vecs[i], d0);
        end

        // Reset while beats are streaming.
        rv = '{64'h6000, 31, -1, -1, -1, 1'b0, 2, 1'b0};
        start_vec(rv);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_r_streaming", bus.DoValid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_arvalid", bus.arvalid, 0);
        chk("mid_rst_rready", bus.rready, 0);
        chk("mid_rst_dovalid", bus.DoValid, 0);
        chk("mid_rst_rqready", bus.RqReady, 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        do_q.delete();
        ar_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        chk("post_rst_arvalid", bus.arvalid, 0);

        d0 = done_cnt;
        start_vec(vecs[0]);
        wait_done(vecs[0], d0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_burst_rd_ctlr.md
Name: axi_burst_rd_ctlr

Overview:
- Parametrised AXI4 read master; next generation of the single-beat read request controller.
- Takes one request (start address, beat count) and splits it into INCR bursts.
- Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary.
- Streams R beats to a ready/valid consumer (inbound RAM fill path), then reports done and sticky error.

Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 128, AXI data width; power of 2, 32..512; BYTES = DATA_W/8.
- ID_W, 4, AXI ID width.
- LEN_W, 16, request beat-count width.
- MAX_BURST, 16, max beats per AR; power of 2, 1..256.
- AXI_ID, 0, constant ARID value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- RqValid  in  1  request valid
- RqReady  out  1  request accepted when RqValid & RqReady
- RqAddr  in  ADDR_W  start byte address; low log2(BYTES) bits ignored
- RqLen  in  LEN_W  beats minus 1
- RqDone  out  1  one-cycle pulse at end of request
- RqErr  out  1  valid with RqDone; sticky error for whole request
- DoValid/DoReady  out/in  1  data-out handshake
- DoData  out  DATA_W  beat data
- DoLast  out  1  final beat of whole request
- DoErr  out  1  this beat had rresp != OKAY
- araddr/arlen/arsize/arburst/arid/arvalid/arready  AXI AR channel (arready input)
- arlock/arprot/arcache/arqos  out  tied 0 / 3'h2 / 0 / 0
- rdata/rid/rresp/rlast/rvalid/rready  AXI R channel (rready output)

Behaviour:
- Reset values: state IDLE; arvalid=0, rready=0, RqDone=0, RqErr=0, DoValid=0; error flag cleared. RqReady=1 once out of reset.
- Constant AR fields: arsize = log2(BYTES); arburst = INCR (2'h1); arid = AXI_ID.
- State IDLE:
  - RqReady=1.
  - On accept, latch addr (aligned to BYTES), remaining = RqLen+1, clear error flag.
  - Go to AR.
- State AR:
  - Compute burst beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/BYTES); arlen = beats-1.
  - arvalid=1 from entry; araddr/arlen held stable until arready (no combinational dependence on arready).
  - On handshake go to R.
  - arvalid is registered: it asserts on the cycle after request accept and after each burst end.
- State R:
  - rready = DoReady; DoValid = rvalid; DoData = rdata (pass-through, 0 latency).
  - Each handshake decrements the burst counter and remaining.
  - DoErr = (rresp != 0); any error sets the sticky flag.
  - DoLast = 1 on the beat where remaining reaches 0.
  - Burst end is set by the beat counter, not rlast. rlast disagreeing with the counter (early or missing) sets the error flag.
  - At burst end: if remaining=0 go to DONE; else addr += beats*BYTES (ADDR_W wrap, no saturation) and go to AR.
- State DONE:
  - RqDone=1 and RqErr=flag for exactly one cycle; go to IDLE.
  - RqReady=0 in DONE; a new request is accepted earliest the cycle after RqDone.
- Errors never abort a request; all beats are drained and forwarded.
- Request count boundaries: RqLen = 2^LEN_W-1 handled (counter width LEN_W+1). RqLen=0 issues a single burst of arlen=0.
- rst during AR or R: outputs return to reset values immediately. The in-flight AXI transaction is abandoned; the interconnect is reset alongside.
- Illegal states go to IDLE.

Optional Feature:
- Macro AXI_RD_ID_CHECK_EN.
- Defined: any R handshake with rid != AXI_ID sets the sticky error flag and DoErr on that beat. The beat is still forwarded and counted.
- Undefined: rid is ignored and unused.

Test Plan:
- Single beat: addr 0x1000, RqLen=0, arready/rvalid immediate, rresp=0 -> one AR (araddr 0x1000, arlen 0, arsize 4), DoLast=1 on that beat, RqDone pulse with RqErr=0.
- Max-burst split: addr 0x0, RqLen=39, MAX_BURST=16 -> ARs at 0x000/0x100/0x200 with arlen 15/15/7, 40 beats out, DoLast only on beat 40.
- 4 KB boundary: addr 0x0FC0, RqLen=7 -> AR 0x0FC0 arlen 3, then AR 0x1000 arlen 3, no AR crosses 0x1000.
- Backpressure/error: DoReady toggling 1-0-1, rresp=2'h2 on beat 2 of 4 -> rready tracks DoReady, DoErr=1 on beat 2 only, all 4 beats delivered, RqErr=1 at RqDone.
- rlast mismatch: RqLen=3 with rlast asserted on beat 2 -> 4 beats still counted, RqErr=1. Separately, rst asserted mid-R -> arvalid/rready/DoValid=0 at once, state IDLE, RqReady=1.
- With AXI_RD_ID_CHECK_EN: rid=4'h3 on beat 1 of 2 -> DoErr=1 on beat 1, RqErr=1. Without the macro, the same stimulus gives RqErr=0.
